decode_ctrl_stage: RTL and testbench
====================================

Name: decode_ctrl_stage

Overview:
Registered, parametrised RV decode stage that turns a fetched 32-bit instruction into the datapath control bundle.
- Sits between the fetch buffer and execute. Carries a valid/ready handshake with a 2-entry skid buffer.
- Supports RV32I/RV64I selection, an optional M extension, and ECALL/EBREAK/illegal trap sequencing.
- After a trap it holds until the pipeline is flushed.

Parameters:
XLEN, 64, 32 or 64; with 32, the W opcodes (0011011, 0111011) decode as illegal.
M_EXT, 1, 1 = funct7 0000001 on R/R-W decodes as MUL/DIV; 0 = illegal.
SKID_DEPTH, 2, output buffer entries; only the value 2 is supported.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept an instruction
i_instr  in  32  instruction word
i_flush  in  1  drop all buffered entries and leave TRAP_WAIT
o_valid  out  1  control bundle valid
i_ready  in  1  downstream accepts the bundle
o_imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
o_result_src  out  3  000 ALU, 001 mem, 010 PC+4, 011 PC+imm, 100 imm
o_alu_op  out  3  000 add, 001 sub/branch, 010 I/R, 011 W, 100 mul/div
o_mem_we, o_reg_we, o_alu_src, o_branch, o_jump, o_pc_target_src, o_mem_access, o_load_instr  out  1 each  control flags
o_forward_src  out  2  00 ALU, 01 PC target, 10 imm
o_trap  out  1  bundle is a trap
o_cause  out  4  trap cause, 0 when o_trap=0

Behaviour:
Reset:
- All outputs 0; o_ready=1; buffer empty; state RUN.

Handshake:
- Accept when i_valid & o_ready.
- The decoded bundle is registered and appears with o_valid=1 the next cycle (latency 1).
- Bundle transfers when o_valid & i_ready.
- o_valid and the bundle stay stable while i_ready=0.
- o_ready=0 when both entries are occupied or state is TRAP_WAIT.
- o_ready is a registered signal.
- Simultaneous accept and transfer keeps the occupancy unchanged.
- Skid buffer is FIFO-ordered. The entry slot wraps 1→0.

Decode:
- Same flag set per class as the existing single-cycle decoder: load, ALU-imm, JALR, ALU-W-imm, store, R, R-W, branch, JAL, AUIPC, LUI.
- JALR: o_pc_target_src=1.
- AUIPC: o_forward_src=01.
- LUI: o_forward_src=10.
- M_EXT R/R-W with funct7=0000001: o_alu_op=100, o_reg_we=1.
- Other funct7 with instr[25]=1 on R/R-W: illegal.

Traps (mutually exclusive with all other flags):
- SYSTEM with funct3=000 and instr[20]=0: ECALL, cause 1011.
- SYSTEM with funct3=000 and instr[20]=1: EBREAK, cause 0011.
- Any other SYSTEM, unknown opcode, or illegal per XLEN/M_EXT: cause 0010.
- All-zero opcode 0000000: valid bubble with all flags 0, o_trap=0.

State machine:
- RUN → TRAP_WAIT on accepting any trapping instruction. Entries behind the trap are not accepted.
- TRAP_WAIT: o_ready=0. The trap bundle still drains normally.
- TRAP_WAIT → RUN only on i_flush.

Flush:
- i_flush: next cycle buffer empty, o_valid=0, state RUN, o_ready=1.
- An instruction presented in the flush cycle is dropped.
- Flush has priority over accept and over trap entry.

Reset during operation:
- Same result as flush, plus clears all outputs.

Optional Feature:
DECODE_PERF_CNT_EN
- Defined: adds ports o_instr_cnt (64, out) and o_trap_cnt (32, out).
  - Both increment on each transferred bundle: o_instr_cnt for non-bubble, non-trap bundles; o_trap_cnt for trap bundles.
  - Both saturate at all-ones. Both clear on i_rst only, not on i_flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- addi x1,x0,5 (0x00500093), i_ready=1 → next cycle o_valid=1, o_reg_we=1, o_alu_src=1, o_alu_op=010, o_imm_src=000, o_trap=0.
- Stream of 4 instrs with i_ready=0 → o_ready falls after 2 accepts; raise i_ready → 4 bundles emerge in order, none lost or duplicated.
- ecall 0x00000073 then addi → o_trap=1, o_cause=1011; addi not accepted until i_flush pulsed; after flush o_ready=1, state RUN.
- XLEN=32, addiw 0x0050009B → o_trap=1, o_cause=0010. XLEN=64, same word → o_alu_op=011, no trap.
- M_EXT=1, mul 0x02208033 → o_alu_op=100. M_EXT=0, same word → o_cause=0010. Word 0x00000000 → o_valid=1, all flags 0.
- DECODE_PERF_CNT_EN: 3 legal + 1 ebreak (0x00100073) transferred, then a bubble → o_instr_cnt=3, o_trap_cnt=1. Flush leaves counts unchanged; i_rst clears them.

Source files
------------

// File: rtl/decode_ctrl_stage_if.sv
// Handshake and control-bundle bus of the decode stage: fetch side (i_valid/o_ready/i_instr),
// execute side (o_valid/i_ready/bundle) and the pipeline flush.
interface decode_ctrl_stage_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_imm_src;
  logic [2:0]  o_result_src;
  logic [2:0]  o_alu_op;
  logic        o_mem_we;
  logic        o_reg_we;
  logic        o_alu_src;
  logic        o_branch;
  logic        o_jump;
  logic        o_pc_target_src;
  logic        o_mem_access;
  logic        o_load_instr;
  logic [1:0]  o_forward_src;
  logic        o_trap;
  logic [3:0]  o_cause;

  // Driven by the surrounding pipeline (fetch + execute).
  modport master (
    output i_valid, i_instr, i_flush, i_ready,
    input  o_ready, o_valid, o_imm_src, o_result_src, o_alu_op, o_mem_we, o_reg_we,
           o_alu_src, o_branch, o_jump, o_pc_target_src, o_mem_access, o_load_instr,
           o_forward_src, o_trap, o_cause
  );

  // Used by the decode stage itself.
  modport slave (
    input  i_valid, i_instr, i_flush, i_ready,
    output o_ready, o_valid, o_imm_src, o_result_src, o_alu_op, o_mem_we, o_reg_we,
           o_alu_src, o_branch, o_jump, o_pc_target_src, o_mem_access, o_load_instr,
           o_forward_src, o_trap, o_cause
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I/RV64I(+M) decode stage with a 2-entry FIFO skid buffer and trap hold-off.
// Define DECODE_PERF_CNT_EN to add the saturating o_instr_cnt / o_trap_cnt counters.
module decode_ctrl_stage #(
  parameter int XLEN       = 64,
  parameter int M_EXT      = 1,
  parameter int SKID_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
`ifdef DECODE_PERF_CNT_EN
  output logic [63:0]        o_instr_cnt,
  output logic [31:0]        o_trap_cnt,
`endif
  decode_ctrl_stage_if.slave bus
);

  localparam logic [6:0] OP_NONE   = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM_W  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_R_W    = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [2:0] imm_src;
    logic [2:0] result_src;
    logic [2:0] alu_op;
    logic       mem_we;
    logic       reg_we;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       pc_target_src;
    logic       mem_access;
    logic       load_instr;
    logic [1:0] forward_src;
    logic       trap;
    logic [3:0] cause;
  } ctrl_t;

  typedef enum logic {RUN, TRAP_WAIT} state_t;

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    logic  illegal;
    c       = '0;
    illegal = 1'b0;
    case (instr[6:0])
      OP_NONE: ;
      OP_LOAD: begin
        c.reg_we = 1'b1; c.alu_src = 1'b1; c.mem_access = 1'b1; c.load_instr = 1'b1;
        c.result_src = 3'b001;
      end
      OP_IMM:   begin c.reg_we = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b010; end
      OP_IMM_W: begin
        if (XLEN == 32) illegal = 1'b1;
        else begin c.reg_we = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b011; end
      end
      OP_JALR: begin
        c.reg_we = 1'b1; c.alu_src = 1'b1; c.jump = 1'b1; c.pc_target_src = 1'b1;
        c.result_src = 3'b010;
      end
      OP_STORE: begin
        c.imm_src = 3'b001; c.alu_src = 1'b1; c.mem_we = 1'b1; c.mem_access = 1'b1;
      end
      OP_R, OP_R_W: begin
        if (instr[6:0] == OP_R_W && XLEN == 32) illegal = 1'b1;
        else begin
          c.reg_we = 1'b1;
          c.alu_op = (instr[6:0] == OP_R) ? 3'b010 : 3'b011;
          // funct7[0] set is only legal as the M-extension encoding.
          if (instr[25]) begin
            if (M_EXT != 0 && instr[31:25] == 7'b0000001) c.alu_op = 3'b100;
            else illegal = 1'b1;
          end
        end
      end
      OP_BRANCH: begin c.imm_src = 3'b010; c.branch = 1'b1; c.alu_op = 3'b001; end
      OP_JAL: begin
        c.imm_src = 3'b011; c.reg_we = 1'b1; c.jump = 1'b1; c.result_src = 3'b010;
      end
      OP_AUIPC: begin
        c.imm_src = 3'b100; c.reg_we = 1'b1; c.result_src = 3'b011; c.forward_src = 2'b01;
      end
      OP_LUI: begin
        c.imm_src = 3'b100; c.reg_we = 1'b1; c.result_src = 3'b100; c.forward_src = 2'b10;
      end
      OP_SYSTEM: begin
        if (instr[14:12] == 3'b000) begin
          c.trap  = 1'b1;
          c.cause = instr[20] ? 4'b0011 : 4'b1011;
        end else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      c       = '0;
      c.trap  = 1'b1;
      c.cause = 4'b0010;
    end
    return c;
  endfunction

  ctrl_t        mem_q [SKID_DEPTH];
  ctrl_t        in_ctrl, out_ctrl;
  state_t       state_q, state_d;
  logic [1:0]   count_q, count_d;
  logic         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic         ready_q, ready_d;
  logic         valid, accept, xfer;
  logic         unused_instr_bits;

  assign unused_instr_bits = ^{bus.i_instr[24:21], bus.i_instr[19:15], bus.i_instr[11:7]};

  assign in_ctrl = decode(bus.i_instr);
  assign valid   = (count_q != 2'd0);
  assign accept  = bus.i_valid & ready_q;
  assign xfer    = valid & bus.i_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.i_flush) begin
      state_d  = RUN;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (state_q == RUN && accept && in_ctrl.trap) state_d = TRAP_WAIT;
      // One-bit pointers wrap 1->0 naturally for the two-entry buffer.
      if (accept) wr_ptr_d = ~wr_ptr_q;
      if (xfer)   rd_ptr_d = ~rd_ptr_q;
      case ({accept, xfer})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    ready_d = (count_d != 2'(SKID_DEPTH)) && (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= RUN;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // NOTE: buffer storage is not reset; outputs are gated by o_valid, so stale entries are never visible.
  always_ff @(posedge i_clk) begin
    if (accept && !bus.i_flush) mem_q[wr_ptr_q] <= in_ctrl;
  end

  assign out_ctrl = valid ? mem_q[rd_ptr_q] : '0;

  assign bus.o_ready         = ready_q;
  assign bus.o_valid         = valid;
  assign bus.o_imm_src       = out_ctrl.imm_src;
  assign bus.o_result_src    = out_ctrl.result_src;
  assign bus.o_alu_op        = out_ctrl.alu_op;
  assign bus.o_mem_we        = out_ctrl.mem_we;
  assign bus.o_reg_we        = out_ctrl.reg_we;
  assign bus.o_alu_src       = out_ctrl.alu_src;
  assign bus.o_branch        = out_ctrl.branch;
  assign bus.o_jump          = out_ctrl.jump;
  assign bus.o_pc_target_src = out_ctrl.pc_target_src;
  assign bus.o_mem_access    = out_ctrl.mem_access;
  assign bus.o_load_instr    = out_ctrl.load_instr;
  assign bus.o_forward_src   = out_ctrl.forward_src;
  assign bus.o_trap          = out_ctrl.trap;
  assign bus.o_cause         = out_ctrl.cause;

`ifdef DECODE_PERF_CNT_EN
  // Every legal non-bubble class sets at least one of these; bubbles and traps set none.
  logic out_is_instr;
  assign out_is_instr = out_ctrl.reg_we | out_ctrl.mem_we | out_ctrl.branch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_instr_cnt <= '0;
      o_trap_cnt  <= '0;
    end else if (xfer) begin
      if (out_is_instr && !(&o_instr_cnt)) o_instr_cnt <= o_instr_cnt + 64'd1;
      if (out_ctrl.trap && !(&o_trap_cnt)) o_trap_cnt <= o_trap_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed self-checking bench: main DUT (XLEN=64, M_EXT=1) plus a second DUT (XLEN=32, M_EXT=0)
// driven in parallel for the XLEN/M_EXT legality vectors.
module tb_decode_ctrl_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage_if if_a ();
  decode_ctrl_stage_if if_b ();

`ifdef DECODE_PERF_CNT_EN
  logic [63:0] instr_cnt_a, instr_cnt_b;
  logic [31:0] trap_cnt_a, trap_cnt_b;
`endif

  decode_ctrl_stage #(.XLEN(64), .M_EXT(1), .SKID_DEPTH(2)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef DECODE_PERF_CNT_EN
    .o_instr_cnt (instr_cnt_a),
    .o_trap_cnt  (trap_cnt_a),
`endif
    .bus         (if_a)
  );

  decode_ctrl_stage #(.XLEN(32), .M_EXT(0), .SKID_DEPTH(2)) u_dut32 (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef DECODE_PERF_CNT_EN
    .o_instr_cnt (instr_cnt_b),
    .o_trap_cnt  (trap_cnt_b),
`endif
    .bus         (if_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected-bundle packing: {imm, result, alu_op, flags, fwd, trap, cause};
  // flags = {mem_we, reg_we, alu_src, branch, jump, pc_target_src, mem_access, load_instr}.
  function automatic logic [23:0] mk(input logic [2:0] imm, input logic [2:0] res,
                                     input logic [2:0] op, input logic [7:0] fl,
                                     input logic [1:0] fwd, input logic trap,
                                     input logic [3:0] cause);
    return {imm, res, op, fl, fwd, trap, cause};
  endfunction

  function automatic logic [23:0] sig_a();
    return {if_a.o_imm_src, if_a.o_result_src, if_a.o_alu_op, if_a.o_mem_we, if_a.o_reg_we,
            if_a.o_alu_src, if_a.o_branch, if_a.o_jump, if_a.o_pc_target_src,
            if_a.o_mem_access, if_a.o_load_instr, if_a.o_forward_src, if_a.o_trap, if_a.o_cause};
  endfunction

  function automatic logic [23:0] sig_b();
    return {if_b.o_imm_src, if_b.o_result_src, if_b.o_alu_op, if_b.o_mem_we, if_b.o_reg_we,
            if_b.o_alu_src, if_b.o_branch, if_b.o_jump, if_b.o_pc_target_src,
            if_b.o_mem_access, if_b.o_load_instr, if_b.o_forward_src, if_b.o_trap, if_b.o_cause};
  endfunction

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] EBRK  = 32'h00100073;

  typedef struct {
    logic [31:0] instr;
    logic [23:0] exp_a;
    logic [23:0] exp_b;
    string       name;
  } vec_t;

  logic [31:0] stream_instr [4];
  logic [23:0] stream_exp   [4];
  logic [23:0] got_q [$];
  vec_t        vecs [$];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int cyc;
    logic [23:0] trap2, trap3;
    trap2 = mk(3'd0, 3'd0, 3'd0, 8'b0, 2'd0, 1'b1, 4'b0010);
    trap3 = mk(3'd0, 3'd0, 3'd0, 8'b0, 2'd0, 1'b1, 4'b0011);

    rst = 1'b1;
    if_a.i_valid = 1'b0; if_a.i_instr = '0; if_a.i_flush = 1'b0; if_a.i_ready = 1'b0;
    if_b.i_valid = 1'b0; if_b.i_instr = '0; if_b.i_flush = 1'b0; if_b.i_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", if_a.o_valid, 0);
    check("rst_ready", if_a.o_ready, 1);
    check("rst_bundle", sig_a(), 0);
    rst = 1'b0;
    tick();

    // Single addi, latency 1.
    if_a.i_ready = 1'b1; if_a.i_valid = 1'b1; if_a.i_instr = ADDI;
    tick();
    if_a.i_valid = 1'b0;
    check("addi_valid", if_a.o_valid, 1);
    check("addi_bundle", sig_a(), mk(3'd0, 3'd0, 3'b010, 8'b01100000, 2'd0, 1'b0, 4'd0));
    tick();
    check("addi_drained", if_a.o_valid, 0);

    // Four-instruction stream against a stalled consumer.
    stream_instr[0] = ADDI; stream_exp[0] = mk(3'd0, 3'd0, 3'b010, 8'b01100000, 2'd0, 1'b0, 4'd0);
    stream_instr[1] = LW;   stream_exp[1] = mk(3'd0, 3'b001, 3'd0, 8'b01100011, 2'd0, 1'b0, 4'd0);
    stream_instr[2] = SW;   stream_exp[2] = mk(3'b001, 3'd0, 3'd0, 8'b10100010, 2'd0, 1'b0, 4'd0);
    stream_instr[3] = BEQ;  stream_exp[3] = mk(3'b010, 3'd0, 3'b001, 8'b00010000, 2'd0, 1'b0, 4'd0);
    if_a.i_ready = 1'b0; if_a.i_valid = 1'b1; if_a.i_instr = stream_instr[0];
    check("stream_rdy0", if_a.o_ready, 1);
    tick();
    if_a.i_instr = stream_instr[1];
    tick();
    check("stream_full", if_a.o_ready, 0);
    if_a.i_instr = stream_instr[2];
    tick();
    check("stream_hold_rdy", if_a.o_ready, 0);
    check("stream_hold_valid", if_a.o_valid, 1);
    check("stream_hold_bundle", sig_a(), stream_exp[0]);
    sent = 2;
    cyc  = 0;
    if_a.i_ready = 1'b1;
    while (got_q.size() < 4 && cyc < 20) begin
      if (if_a.o_valid && if_a.i_ready) got_q.push_back(sig_a());
      if (if_a.i_valid && if_a.o_ready) sent++;
      tick();
      if_a.i_valid = (sent < 4);
      if (sent < 4) if_a.i_instr = stream_instr[sent];
      cyc++;
    end
    if_a.i_valid = 1'b0;
    check("stream_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("stream_order%0d", i), got_q[i], stream_exp[i]);
    check("stream_empty", if_a.o_valid, 0);

    // ECALL followed by addi: trap drains, addi held until flush.
    if_a.i_ready = 1'b0; if_a.i_valid = 1'b1; if_a.i_instr = ECALL;
    tick();
    if_a.i_instr = ADDI;
    check("ecall_bundle", sig_a(), mk(3'd0, 3'd0, 3'd0, 8'b0, 2'd0, 1'b1, 4'b1011));
    check("ecall_rdy", if_a.o_ready, 0);
    repeat (3) tick();
    check("trap_wait_rdy", if_a.o_ready, 0);
    if_a.i_ready = 1'b1;
    tick();
    check("trap_no_accept", if_a.o_valid, 0);
    check("trap_still_wait", if_a.o_ready, 0);
    if_a.i_flush = 1'b1;
    tick();
    if_a.i_flush = 1'b0; if_a.i_valid = 1'b0;
    check("flush_rdy", if_a.o_ready, 1);
    check("flush_valid", if_a.o_valid, 0);
    tick();
    check("flush_drop", if_a.o_valid, 0);
    if_a.i_valid = 1'b1; if_a.i_instr = ADDI;
    tick();
    if_a.i_valid = 1'b0;
    check("run_after_flush", sig_a(), stream_exp[0]);

    // Decode table on both DUTs; each vector is followed by a flush to leave any trap state.
    vecs.push_back('{32'h0050009B, mk(3'd0, 3'd0, 3'b011, 8'b01100000, 2'd0, 1'b0, 4'd0), trap2, "addiw"});
    vecs.push_back('{32'h02208033, mk(3'd0, 3'd0, 3'b100, 8'b01000000, 2'd0, 1'b0, 4'd0), trap2, "mul"});
    vecs.push_back('{32'h00000000, 24'd0, 24'd0, "bubble"});
    vecs.push_back('{32'h0020803B, mk(3'd0, 3'd0, 3'b011, 8'b01000000, 2'd0, 1'b0, 4'd0), trap2, "addw"});
    vecs.push_back('{32'h40208033, mk(3'd0, 3'd0, 3'b010, 8'b01000000, 2'd0, 1'b0, 4'd0),
                     mk(3'd0, 3'd0, 3'b010, 8'b01000000, 2'd0, 1'b0, 4'd0), "sub"});
    vecs.push_back('{32'h123450B7, mk(3'b100, 3'b100, 3'd0, 8'b01000000, 2'b10, 1'b0, 4'd0),
                     mk(3'b100, 3'b100, 3'd0, 8'b01000000, 2'b10, 1'b0, 4'd0), "lui"});
    vecs.push_back('{32'h00000097, mk(3'b100, 3'b011, 3'd0, 8'b01000000, 2'b01, 1'b0, 4'd0),
                     mk(3'b100, 3'b011, 3'd0, 8'b01000000, 2'b01, 1'b0, 4'd0), "auipc"});
    vecs.push_back('{32'h000080E7, mk(3'd0, 3'b010, 3'd0, 8'b01101100, 2'd0, 1'b0, 4'd0),
                     mk(3'd0, 3'b010, 3'd0, 8'b01101100, 2'd0, 1'b0, 4'd0), "jalr"});
    vecs.push_back('{32'h008000EF, mk(3'b011, 3'b010, 3'd0, 8'b01001000, 2'd0, 1'b0, 4'd0),
                     mk(3'b011, 3'b010, 3'd0, 8'b01001000, 2'd0, 1'b0, 4'd0), "jal"});
    vecs.push_back('{32'h30001073, trap2, trap2, "csrrw"});
    vecs.push_back('{32'h0000007F, trap2, trap2, "unknown"});
    vecs.push_back('{32'h06208033, trap2, trap2, "bad_funct7"});
    vecs.push_back('{EBRK, trap3, trap3, "ebreak"});
    foreach (vecs[i]) begin
      if_a.i_valid = 1'b1; if_a.i_instr = vecs[i].instr;
      if_b.i_valid = 1'b1; if_b.i_instr = vecs[i].instr;
      tick();
      if_a.i_valid = 1'b0; if_b.i_valid = 1'b0;
      check({vecs[i].name, "_valid64"}, if_a.o_valid, 1);
      check({vecs[i].name, "_x64"}, sig_a(), vecs[i].exp_a);
      check({vecs[i].name, "_x32"}, sig_b(), vecs[i].exp_b);
      if_a.i_flush = 1'b1; if_b.i_flush = 1'b1;
      tick();
      if_a.i_flush = 1'b0; if_b.i_flush = 1'b0;
    end

`ifdef DECODE_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_rst_instr", instr_cnt_a, 0);
    check("perf_rst_trap", trap_cnt_a, 0);
    if_a.i_ready = 1'b1;
    if_a.i_valid = 1'b1;
    if_a.i_instr = ADDI; tick();
    if_a.i_instr = LW;   tick();
    if_a.i_instr = SW;   tick();
    if_a.i_instr = EBRK; tick();
    if_a.i_valid = 1'b0;
    tick();
    if_a.i_flush = 1'b1; tick(); if_a.i_flush = 1'b0;
    if_a.i_valid = 1'b1; if_a.i_instr = 32'h0; tick();
    if_a.i_valid = 1'b0;
    repeat (2) tick();
    check("perf_instr", instr_cnt_a, 3);
    check("perf_trap", trap_cnt_a, 1);
    if_a.i_flush = 1'b1; tick(); if_a.i_flush = 1'b0;
    check("perf_flush_instr", instr_cnt_a, 3);
    check("perf_flush_trap", trap_cnt_a, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("perf_clr_instr", instr_cnt_a, 0);
    check("perf_clr_trap", trap_cnt_a, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
